serial_subtractor: RTL

Bit-serial subtractor computing A - B, LSB first, one bit per clock through a single one-bit full-subtractor cell and a registered borrow. It is the subtraction counterpart to the lab's ripple full-adder datapath. A start/busy/done handshake brackets each operation. Used where area matters more than latency, e.g. the lab ALU's slow path.

---
 rtl/serial_arith_pkg.sv | 30 +++
 rtl/full_subtractor.sv | 21 ++
 rtl/serial_subtractor.sv | 113 +++++++++++
 3 files changed

// File: rtl/serial_arith_pkg.sv
// ============================================================================
//  Module      : serial_arith_pkg
//  Description : Shared types and helpers for the bit-serial arithmetic units.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Bits needed to index 0..value-1 (ceil(log2(value))).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/full_subtractor.sv
// ============================================================================
//  Module      : full_subtractor
//  Description : One-bit combinational full subtractor (a - b - bin).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
//  Module      : serial_subtractor
//  Description : LSB-first bit-serial A - B with start/busy/done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             ovf
);

    localparam int               c_CNT_W = clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_res;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_bin;
    logic               r_a_msb;
    logic               r_b_msb;

    logic               w_d;
    logic               w_bout;
    logic [WIDTH-1:0]   w_res_next;

    full_subtractor u_fs (
        .a    (r_a_sh[0]),
        .b    (r_b_sh[0]),
        .bin  (r_bin),
        .d    (w_d),
        .bout (w_bout)
    );

    // Result fills from the MSB side so bit 0 lands at position 0 after WIDTH shifts.
    assign w_res_next = {w_d, r_res[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_a_sh     <= '0;
            r_b_sh     <= '0;
            r_res      <= '0;
            r_cnt      <= '0;
            r_bin      <= 1'b0;
            r_a_msb    <= 1'b0;
            r_b_msb    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_bin   <= 1'b0;
                        r_cnt   <= '0;
                        r_a_msb <= a[WIDTH-1];
                        r_b_msb <= b[WIDTH-1];
                        busy    <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_a_sh <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_res  <= w_res_next;
                    r_bin  <= w_bout;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        diff       <= w_res_next;
                        borrow_out <= w_bout;
                        // Overflow only when operand signs differ and result sign departs from A.
                        ovf        <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
                        r_state    <= DONE;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
